// File: rtl/xadac_spm.sv
// xadac_spm: single-port AXI scratchpad that serves one single-beat read or write at a time.
// Define XADAC_SPM_ZERO_INIT_EN to zero the whole array after every reset before taking traffic.
module xadac_spm #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [IdWidth-1:0]     aw_id,
  input  logic [AddrWidth-1:0]   aw_addr,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [DataWidth-1:0]   w_data,
  input  logic [DataWidth/8-1:0] w_strb,
  input  logic                   w_valid,
  output logic                   w_ready,
  output logic [IdWidth-1:0]     b_id,
  output logic                   b_valid,
  input  logic                   b_ready,
  input  logic [IdWidth-1:0]     ar_id,
  input  logic [AddrWidth-1:0]   ar_addr,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  output logic [IdWidth-1:0]     r_id,
  output logic [DataWidth-1:0]   r_data,
  output logic                   r_valid,
  input  logic                   r_ready
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = $clog2(Depth);

  typedef enum logic [1:0] {StIdle, StRresp, StBresp, StInit} state_e;

  state_e               r_state, w_state_d;
  logic                 r_aw_held, r_w_held, r_last_rd;
  logic [IdWidth-1:0]   r_aw_id, r_rid, r_bid;
  logic [IdxW-1:0]      r_aw_idx;
  logic [DataWidth-1:0] r_wdata, r_rdata;
  logic [StrbWidth-1:0] r_wstrb;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_idle, w_ar_hs, w_aw_hs, w_w_hs, w_wr_done;
  logic [IdxW-1:0]      w_wr_idx, w_ar_idx;
  logic [DataWidth-1:0] w_wr_data;
  logic [StrbWidth-1:0] w_wr_strb;
  logic [IdWidth-1:0]   w_wr_id;
  logic                 w_unused;

  // Address bits outside the word index are deliberately ignored (aliasing).
  assign w_unused = ^{aw_addr, ar_addr};

  assign w_idle   = rstn && (r_state == StIdle);
  // A waiting full write pair beats a read only when the previous transaction was a read.
  assign ar_ready = w_idle && !r_aw_held && !r_w_held && !(aw_valid && w_valid && r_last_rd);
  assign w_ar_hs  = ar_valid && ar_ready;
  assign aw_ready = w_idle && !r_aw_held && !w_ar_hs;
  assign w_ready  = w_idle && !r_w_held && !w_ar_hs;
  assign w_aw_hs  = aw_valid && aw_ready;
  assign w_w_hs   = w_valid && w_ready;
  assign w_wr_done = (w_aw_hs || w_w_hs) && (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held);

  assign w_ar_idx  = ar_addr[OffW +: IdxW];
  assign w_wr_idx  = w_aw_hs ? aw_addr[OffW +: IdxW] : r_aw_idx;
  assign w_wr_id   = w_aw_hs ? aw_id : r_aw_id;
  assign w_wr_data = w_w_hs ? w_data : r_wdata;
  assign w_wr_strb = w_w_hs ? w_strb : r_wstrb;

  assign r_valid = (r_state == StRresp);
  assign b_valid = (r_state == StBresp);
  assign r_data  = r_rdata;
  assign r_id    = r_rid;
  assign b_id    = r_bid;

`ifdef XADAC_SPM_ZERO_INIT_EN
  localparam state_e ResetState = StInit;

  logic [IdxW-1:0] r_init_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_init_idx <= '0;
    end else if (r_state == StInit) begin
      r_init_idx <= r_init_idx + IdxW'(1);
    end
  end
`else
  localparam state_e ResetState = StIdle;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_ar_hs) begin
          w_state_d = StRresp;
        end else if (w_wr_done) begin
          w_state_d = StBresp;
        end
      end
      StRresp: if (r_ready) w_state_d = StIdle;
      StBresp: if (b_ready) w_state_d = StIdle;
`ifdef XADAC_SPM_ZERO_INIT_EN
      StInit:  if (r_init_idx == IdxW'(Depth - 1)) w_state_d = StIdle;
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ResetState;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_last_rd <= 1'b0;
      r_aw_id   <= '0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_bid     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_wr_done) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bid     <= w_wr_id;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_id   <= aw_id;
          r_aw_idx  <= aw_addr[OffW +: IdxW];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= w_data;
          r_wstrb  <= w_strb;
        end
      end
      if (w_ar_hs) begin
        r_rdata <= r_mem[w_ar_idx];
        r_rid   <= ar_id;
      end
      if (r_valid && r_ready) begin
        r_last_rd <= 1'b1;
      end else if (b_valid && b_ready) begin
        r_last_rd <= 1'b0;
      end
    end
  end

  // Byte-enabled array write; the zero sweep and traffic writes never coincide.
  always_ff @(posedge clk) begin
    if (w_wr_done) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (w_wr_strb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
`ifdef XADAC_SPM_ZERO_INIT_EN
    if (r_state == StInit) begin
      r_mem[r_init_idx] <= '0;
    end
`endif
  end

endmodule

// File: tb/tb_xadac_spm.sv
// Scoreboard bench for xadac_spm: driver pushes expected responses from a word-array model,
// a monitor pops and compares on every R/B handshake.
module tb_xadac_spm;

  localparam int DW    = 128;
  localparam int AW    = 64;
  localparam int IW    = 4;
  localparam int DEPTH = 16;

  logic          clk, rstn;
  logic [IW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [DW-1:0] w_data, r_data;
  logic [DW/8-1:0] w_strb;

  xadac_spm #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .Depth(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {
    bit            is_rd;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    bit            chk_data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mdl [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            bp_mode  = 0;  // 0: always ready, 1: random, 2: stalled

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within bound, required one", name);
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / 16) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] s);
    logic [DW-1:0] res = old;
    for (int b = 0; b < DW / 8; b++) if (s[b]) res[8*b +: 8] = d[8*b +: 8];
    return res;
  endfunction

  // Response backpressure generator.
  initial begin
    r_ready = 1'b0;
    b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: begin r_ready = 1'b1; b_ready = 1'b1; end
        1: begin r_ready = 1'($urandom_range(0, 1)); b_ready = 1'($urandom_range(0, 1)); end
        default: begin r_ready = 1'b0; b_ready = 1'b0; end
      endcase
    end
  end

  // Monitor: pops expectations on handshakes, checks stall stability and quiet readies.
  initial begin
    exp_t          e;
    bit            stall_r = 0, stall_b = 0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_rid, prev_bid;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_r = 0;
        stall_b = 0;
      end else begin
        if (stall_r && r_valid) begin
          chk("r_data_stable", r_data, prev_data);
          chk("r_id_stable", r_id, prev_rid);
        end
        if (stall_b && b_valid) chk("b_id_stable", b_id, prev_bid);
        if (r_valid || b_valid) chk("readies_in_resp", {ar_ready, aw_ready, w_ready}, 0);
        if (r_valid && r_ready) begin
          if (q.size() == 0) begin
            timeout_fail("r_unexpected");
          end else begin
            e = q.pop_front();
            chk("resp_kind_r", 1'b1, e.is_rd);
            chk("r_id", r_id, e.id);
            if (e.chk_data) chk("r_data", r_data, e.data);
          end
        end
        if (b_valid && b_ready) begin
          if (q.size() == 0) begin
            timeout_fail("b_unexpected");
          end else begin
            e = q.pop_front();
            chk("resp_kind_b", 1'b0, e.is_rd);
            chk("b_id", b_id, e.id);
          end
        end
        stall_r   = r_valid && !r_ready;
        stall_b   = b_valid && !b_ready;
        prev_data = r_data;
        prev_rid  = r_id;
        prev_bid  = b_id;
      end
    end
  end

  task automatic wait_resp(input bit rd);
    int cyc  = 0;
    bit done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      done = rd ? (r_valid && r_ready) : (b_valid && b_ready);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) timeout_fail(rd ? "r_handshake" : "b_handshake");
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW/8-1:0] strb, input logic [IW-1:0] id, input int lead);
    int idx = widx(addr);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    q.push_back('{is_rd: 1'b0, id: id, data: '0, chk_data: 1'b0});
    mdl[idx] = merge(mdl[idx], data, strb);
    aw_addr = addr;
    aw_id   = id;
    w_data  = data;
    w_strb  = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      aw_valid = !aw_done && (cyc >= (lead < 0 ? -lead : 0));
      w_valid  = !w_done && (cyc >= (lead > 0 ? lead : 0));
      @(negedge clk);
      if (aw_done != w_done) begin
        chk("ar_ready_while_held", ar_ready, 0);
        chk("held_chan_ready", aw_done ? aw_ready : w_ready, 0);
      end
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      @(posedge clk);
      #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    if (!(aw_done && w_done)) timeout_fail("aw_w_handshake");
    else chk("b_valid_latency", b_valid, 1'b1);
    wait_resp(1'b0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [IW-1:0] id);
    int idx = widx(addr);
    int cyc = 0;
    bit hs  = 0;
    q.push_back('{is_rd: 1'b1, id: id, data: mdl[idx], chk_data: 1'b1});
    ar_addr  = addr;
    ar_id    = id;
    ar_valid = 1'b1;
    while (!hs && cyc < 60) begin
      @(negedge clk);
      hs = ar_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    ar_valid = 1'b0;
    if (!hs) timeout_fail("ar_handshake");
    else chk("r_valid_latency", r_valid, 1'b1);
    wait_resp(1'b1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int            cyc, n_hs;
    rstn = 1'b0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_readies", {ar_ready, aw_ready, w_ready}, 0);
    chk("reset_valids", {r_valid, b_valid}, 0);
    chk("reset_r_data", r_data, 0);
    chk("reset_ids", {r_id, b_id}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

`ifdef XADAC_SPM_ZERO_INIT_EN
    cyc = 0;
    n_hs = 0;
    while (cyc < 3 * DEPTH) begin
      @(negedge clk);
      if (ar_ready) break;
      n_hs++;
      cyc++;
    end
    chk("init_blocked_cycles", n_hs, DEPTH);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    do_read(64'($urandom_range(0, DEPTH - 1) * 16), 4'h2);
`else
    for (int i = 0; i < DEPTH; i++) do_write(64'(i * 16), {$urandom, $urandom, $urandom, $urandom},
                                             16'hFFFF, 4'(i), 0);
`endif

    do_write(64'h40, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 16'hFFFF, 4'h3, 0);
    do_read(64'h40, 4'h5);

    do_write(64'h80, {DW{1'b1}}, 16'hFFFF, 4'h1, 0);
    do_write(64'h80, '0, 16'h000F, 4'h2, 0);
    do_read(64'h80, 4'h7);
    chk("partial_strb_model", mdl[8], {{96{1'b1}}, 32'h0});

    do_write(64'h20, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 4'hA, 3);
    do_write(64'h30, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 4'hB, -3);
    do_read(64'h20, 4'hC);
    do_read(64'h30, 4'hD);

    bp_mode = 2;
    fork
      do_read(64'h40, 4'h6);
      begin
        repeat (6) @(posedge clk);
        #1;
        bp_mode = 0;
      end
    join

    bp_mode = 1;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read({$urandom, $urandom}, 4'($urandom));
      end else begin
        do_write({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                 4'($urandom), int'($urandom_range(0, 4)) - 2);
      end
    end

    // All three request channels valid straight out of reset: read and write must alternate.
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    ar_addr = 64'h10;
    ar_id = 4'h9;
    aw_addr = 64'(DEPTH * 16 + 16'h10);
    aw_id = 4'h6;
    w_data = d;
    w_strb = 16'hFFFF;
    ar_valid = 1'b1;
    aw_valid = 1'b1;
    w_valid = 1'b1;
    @(negedge clk);
    chk("reset_readies_valid_in", {ar_ready, aw_ready, w_ready}, 0);
    q.push_back('{is_rd: 1'b1, id: 4'h9, data: '0, chk_data: 1'b0});
    for (int k = 0; k < 2; k++) begin
      q.push_back('{is_rd: 1'b0, id: 4'h6, data: '0, chk_data: 1'b0});
      q.push_back('{is_rd: 1'b1, id: 4'h9, data: d, chk_data: 1'b1});
    end
    q.push_back('{is_rd: 1'b0, id: 4'h6, data: '0, chk_data: 1'b0});
    @(posedge clk);
    #1;
    rstn = 1'b1;
    n_hs = 0;
    cyc = 0;
    while (n_hs < 6 && cyc < 200) begin
      @(negedge clk);
      if (ar_valid && ar_ready) n_hs++;
      if (aw_valid && aw_ready && w_valid && w_ready) n_hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid = 1'b0;
    if (n_hs < 6) timeout_fail("alternating_handshakes");

    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xadac_spm.md
# xadac_spm

Single-port scratchpad memory acting as the AXI subordinate for the xadac accelerator's flattened single-beat AXI channels. It serves full-width vector reads issued by the vload unit and byte-strobed vector writes issued by the vactv unit, one transaction at a time, with registered responses and full valid/ready backpressure. It sits directly downstream of the xadac top-level AXI master in accelerator-local test and integration configurations.

## Interface
Parameters:
- DataWidth, 128, vector data width in bits; power of two, ≥ 32.
- AddrWidth, 64, AXI address width.
- IdWidth, 4, AXI ID width.
- Depth, 1024, number of DataWidth-bit words; power of two.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- aw_id  in  IdWidth  write-address ID.
- aw_addr  in  AddrWidth  write byte address.
- aw_valid / aw_ready  in / out  1  write-address handshake.
- w_data  in  DataWidth  write data.
- w_strb  in  DataWidth/8  byte enables.
- w_valid / w_ready  in / out  1  write-data handshake.
- b_id  out  IdWidth  write-response ID.
- b_valid / b_ready  out / in  1  write-response handshake.
- ar_id  in  IdWidth  read-address ID.
- ar_addr  in  AddrWidth  read byte address.
- ar_valid / ar_ready  in / out  1  read-address handshake.
- r_id  out  IdWidth  read-response ID.
- r_data  out  DataWidth  read data.
- r_valid / r_ready  out / in  1  read-response handshake.

## Operation
- Word index = addr[$clog2(DataWidth/8) +: $clog2(Depth)]. Lower bits are ignored. Upper bits are ignored, so addresses alias modulo Depth words.
- All transactions are single-beat. No response-code ports exist; every response is implicitly OKAY.
- At most one transaction is in flight. States: INIT (only with the macro), IDLE, RRESP, BRESP.
- IDLE, write path:
  - aw_ready = !aw_held; w_ready = !w_held.
  - AW and W may handshake in the same cycle or in different cycles, in either order. A handshake latches the corresponding channel into its holding register.
  - In the cycle the second of AW/W completes, the SRAM write occurs: bytes where w_strb=1 are updated, all others retained. b_id takes aw_id, the state goes to BRESP, and both held flags clear.
- IDLE, read path:
  - ar_ready = !aw_held && !w_held && !(aw_valid && w_valid && last_rd), where last_rd records the kind of the previous completed transaction.
  - A partially captured write blocks reads until the write completes.
  - If ar and a full write pair (aw_valid && w_valid, nothing held) are both presented, round-robin applies: reads win when last_rd=0, writes win when last_rd=1. At reset last_rd=0, so a read wins first.
  - While a read is being accepted, aw_ready and w_ready are forced low.
  - On the AR handshake the SRAM is read. r_data and r_id are registered at the next edge, and the state goes to RRESP.
- RRESP: r_valid=1; r_data and r_id are held stable until r_ready; then go to IDLE and set last_rd=1.
- BRESP: b_valid=1; b_id is held until b_ready; then go to IDLE and set last_rd=0.
- All ready outputs are 0 in RRESP, BRESP and INIT.

## Timing
- Reset values: r_valid=0, b_valid=0, r_data=0, r_id=0, b_id=0, held flags=0, last_rd=0. All readies are 0 while rstn=0.
- Read latency: AR handshake in cycle N gives r_valid=1 in cycle N+1. The earliest next AR handshake is the cycle after the R handshake.
- Write latency: the cycle N in which the last of AW/W handshakes gives b_valid=1 in cycle N+1.
- Read-after-write to the same address returns the new data. A write never overlaps a read.
- r_ready or b_ready held high continuously gives one transaction per 2 cycles.
- Reset mid-operation: pending responses and held AW/W are discarded. Without the macro, memory contents are not guaranteed.

## Configuration
- XADAC_SPM_ZERO_INIT_EN defined:
  - After rstn deassertion the block sits in INIT and writes zero to one word per cycle, index 0 to Depth-1.
  - All readies stay 0 for exactly Depth cycles, then the state goes to IDLE.
  - Reasserting rstn restarts the sweep.
- Undefined: there is no INIT state; IDLE is entered directly from reset and initial memory contents are X.

## Test plan
- Write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 at 0x40 with strb=all-1 and aw_id=3, then read 0x40 with ar_id=5 -> b_id=3; r_data equals the written value with r_id=5; r_valid exactly 1 cycle after the AR handshake.
- Full write of 0xFF.. at 0x80, then write 0x0 with strb=0x000F -> a read returns bytes 0-3 = 0x00 and bytes 4-15 = 0xFF.
- AW presented 3 cycles before W, then the reverse order -> one write each; aw_ready=0 while AW is held; ar_ready=0 throughout; b_valid 1 cycle after the W handshake.
- r_ready held low 5 cycles -> r_valid and r_data stable; no ar/aw/w_ready until the R handshake.
- ar_valid, aw_valid and w_valid all high continuously from reset -> read, write, read, write alternating. A write to Depth*16+0x10 aliases to word 1.
- With XADAC_SPM_ZERO_INIT_EN and Depth=16: ar_ready=0 for 16 cycles after reset, then a read of any word returns 0.
